// File: rtl/gs_update_unit_pkg.sv
// gs_pkg: shared widths, stencil coefficients and FSM states for the Gauss-Seidel update unit
// No ports; imported by gs_row_solver and gs_update_unit.
package gs_pkg;
  localparam int X_W = 32;
  localparam int B_W = 16;
  localparam int FRAC = 16;
  localparam int S_W = 40;
  localparam int C_DIV = 20;
  localparam int C_N1 = 13;
  localparam int C_N2 = 6;
  localparam int C_N3 = 1;
  typedef enum logic [1:0] {IDLE, RUN, OUT, DONE} state_t;
endpackage

// File: rtl/gs_update_unit_if.sv
// gs_update_unit_if: row stream into the update unit and result stream back out
// master drives start_in, b_in, x1_in..x6_in; slave drives x_out, out_valid, done_out.
interface gs_update_unit_if #(
  parameter int X_W = gs_pkg::X_W,
  parameter int B_W = gs_pkg::B_W
);
  logic start_in;
  logic signed [B_W-1:0] b_in;
  logic signed [X_W-1:0] x1_in, x2_in, x3_in, x4_in, x5_in, x6_in;
  logic signed [X_W-1:0] x_out;
  logic out_valid;
  logic done_out;
  modport master (
    output start_in, b_in, x1_in, x2_in, x3_in, x4_in, x5_in, x6_in,
    input x_out, out_valid, done_out
  );
  modport slave (
    input start_in, b_in, x1_in, x2_in, x3_in, x4_in, x5_in, x6_in,
    output x_out, out_valid, done_out
  );
endinterface

// File: rtl/gs_update_unit_row_solver.sv
// gs_row_solver: combinational row update x = sat(floor(S / 20)) for the 7-point stencil
// b_i: integer b of the row; x1_i..x6_i: Q16.16 neighbours at distance 1,1,2,2,3,3; x_o: saturated Q16.16 result.
module gs_row_solver #(
  parameter int X_W = gs_pkg::X_W,
  parameter int B_W = gs_pkg::B_W
) (
  input  logic signed [B_W-1:0] b_i,
  input  logic signed [X_W-1:0] x1_i,
  input  logic signed [X_W-1:0] x2_i,
  input  logic signed [X_W-1:0] x3_i,
  input  logic signed [X_W-1:0] x4_i,
  input  logic signed [X_W-1:0] x5_i,
  input  logic signed [X_W-1:0] x6_i,
  output logic signed [X_W-1:0] x_o
);
  import gs_pkg::*;
  localparam logic signed [S_W-1:0] K_DIV = S_W'(C_DIV);
  localparam logic signed [S_W-1:0] K1 = S_W'(C_N1);
  localparam logic signed [S_W-1:0] K2 = S_W'(C_N2);
  localparam logic signed [S_W-1:0] K3 = S_W'(C_N3);
  localparam logic signed [S_W-1:0] X_MAX = (S_W'(1) <<< (X_W - 1)) - S_W'(1);
  localparam logic signed [S_W-1:0] X_MIN = -(S_W'(1) <<< (X_W - 1));
  logic signed [S_W-1:0] s, q, r, f;
  // Division truncates toward zero; a negative sum with a remainder is pulled down one step to get floor.
  always_comb begin
    s = (S_W'(b_i) <<< FRAC) + K1 * (S_W'(x1_i) + S_W'(x2_i)) - K2 * (S_W'(x3_i) + S_W'(x4_i))
      + K3 * (S_W'(x5_i) + S_W'(x6_i));
    q = s / K_DIV;
    r = s % K_DIV;
    f = (r != '0 && s[S_W-1]) ? q - S_W'(1) : q;
    x_o = f > X_MAX ? X_W'(X_MAX) : f < X_MIN ? X_W'(X_MIN) : X_W'(f);
  end
endmodule

// File: rtl/gs_update_unit.sv
// gs_update_unit: sweeps one row per active cycle, counts sweeps and releases the final sweep's results
// clk_in: clock; rst_n_in: async active-low reset; bus: slave side of gs_update_unit_if
// (rows in on start_in, registered x_out, out_valid on final-sweep results, sticky done_out).
module gs_update_unit #(
  parameter int ITER_NUM = 16,
  parameter int X_W = gs_pkg::X_W,
  parameter int B_W = gs_pkg::B_W
) (
  input logic clk_in,
  input logic rst_n_in,
  gs_update_unit_if.slave bus
);
  import gs_pkg::*;
  localparam int IW = $clog2(ITER_NUM + 1);
  state_t state_q;
  logic [3:0] row_q;
  logic [IW-1:0] iter_q;
  logic signed [X_W-1:0] x_q, x_d;
  logic valid_q, done_q, act, wrap, last_sweep;
  gs_row_solver #(.X_W(X_W), .B_W(B_W)) u_solver (
    .b_i(bus.b_in),
    .x1_i(bus.x1_in),
    .x2_i(bus.x2_in),
    .x3_i(bus.x3_in),
    .x4_i(bus.x4_in),
    .x5_i(bus.x5_in),
    .x6_i(bus.x6_in),
    .x_o(x_d)
  );
  assign act = bus.start_in && state_q != DONE;
  assign wrap = &row_q;
  assign last_sweep = int'(iter_q) == ITER_NUM - 1;
  // IDLE, RUN and OUT all accept the current row as row_q of sweep iter_q; DONE ignores start_in.
  // done_out is raised one edge after the last result, so it never overlaps out_valid.
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q <= IDLE;
      row_q <= '0;
      iter_q <= '0;
      x_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      valid_q <= act && last_sweep;
      done_q <= state_q == DONE;
      if (act) begin
        row_q <= row_q + 4'd1;
        iter_q <= iter_q + IW'(wrap);
        x_q <= x_d;
        state_q <= last_sweep ? (wrap ? DONE : OUT)
                 : (wrap && int'(iter_q) + 2 == ITER_NUM) ? OUT : RUN;
      end
    end
  assign bus.x_out = x_q;
  assign bus.out_valid = valid_q;
  assign bus.done_out = done_q;
endmodule

// File: tb/tb_gs_update_unit.sv
// tb_gs_update_unit: directed and random row streams against a count-based reference model
module tb_gs_update_unit;
  localparam int IT = 2;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b1;
  always #5 clk_in = ~clk_in;
  gs_update_unit_if bus ();
  gs_update_unit_if bus1 ();
  assign bus1.start_in = bus.start_in;
  assign bus1.b_in = bus.b_in;
  assign bus1.x1_in = bus.x1_in;
  assign bus1.x2_in = bus.x2_in;
  assign bus1.x3_in = bus.x3_in;
  assign bus1.x4_in = bus.x4_in;
  assign bus1.x5_in = bus.x5_in;
  assign bus1.x6_in = bus.x6_in;
  gs_update_unit #(.ITER_NUM(IT)) dut (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus));
  gs_update_unit #(.ITER_NUM(1)) dut1 (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus1));
  int checks = 0;
  int fails = 0;
  int n [2];
  bit fin [2];
  logic [31:0] xe [2];
  bit ve [2];
  bit de [2];
  int iters [2] = '{IT, 1};
  int vcnt, first_v, first_d;
  logic [31:0] xz [6];
  logic [31:0] xs [6];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Row sum in 64-bit arithmetic, floor via a non-negative modulus, then clamp to 32 bits.
  function automatic logic [31:0] ref_x(input logic signed [15:0] b, input logic [31:0] xv [6]);
    longint s, m, hi, lo;
    hi = (longint'(1) <<< 31) - 1;
    lo = -(longint'(1) <<< 31);
    s = longint'(b) * 65536
      + 13 * (longint'($signed(xv[0])) + longint'($signed(xv[1])))
      - 6 * (longint'($signed(xv[2])) + longint'($signed(xv[3])))
      + (longint'($signed(xv[4])) + longint'($signed(xv[5])));
    m = ((s % 20) + 20) % 20;
    s = (s - m) / 20;
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return s[31:0];
  endfunction
  function automatic logic [31:0] rx();
    logic [31:0] v;
    v = $urandom;
    return 32'($signed(v) >>> $urandom_range(0, 24));
  endfunction
  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      n[k] = 0;
      fin[k] = 1'b0;
      xe[k] = '0;
      ve[k] = 1'b0;
      de[k] = 1'b0;
    end
  endtask
  task automatic check_all(input string ph);
    chk({ph, " x_out"}, bus.x_out, xe[0]);
    chk({ph, " out_valid"}, 32'(bus.out_valid), 32'(ve[0]));
    chk({ph, " done_out"}, 32'(bus.done_out), 32'(de[0]));
    chk({ph, " x_out it1"}, bus1.x_out, xe[1]);
    chk({ph, " out_valid it1"}, 32'(bus1.out_valid), 32'(ve[1]));
    chk({ph, " done_out it1"}, 32'(bus1.done_out), 32'(de[1]));
  endtask
  // Accepted rows are counted; row n belongs to sweep n/16, and done follows one edge after the last row.
  task automatic step(input string ph, input logic st, input logic signed [15:0] b, input logic [31:0] xv [6]);
    logic [31:0] ex;
    bus.start_in = st;
    bus.b_in = b;
    bus.x1_in = xv[0];
    bus.x2_in = xv[1];
    bus.x3_in = xv[2];
    bus.x4_in = xv[3];
    bus.x5_in = xv[4];
    bus.x6_in = xv[5];
    ex = ref_x(b, xv);
    @(posedge clk_in);
    #1;
    for (int k = 0; k < 2; k++) begin
      de[k] = fin[k];
      ve[k] = st && !fin[k] && (n[k] / 16 == iters[k] - 1);
      if (st && !fin[k]) begin
        xe[k] = ex;
        n[k]++;
        fin[k] = n[k] == 16 * iters[k];
      end
    end
    if (bus.out_valid) vcnt++;
    check_all(ph);
  endtask
  task automatic rstep(input string ph, input logic st);
    logic [31:0] xv [6];
    for (int i = 0; i < 6; i++) xv[i] = rx();
    step(ph, st, 16'($urandom), xv);
  endtask
  task automatic do_reset(input string ph);
    bus.start_in = 1'b0;
    rst_n_in = 1'b0;
    #1;
    reset_model();
    check_all({ph, " async"});
    @(posedge clk_in);
    #1;
    check_all({ph, " held"});
    rst_n_in = 1'b1;
    vcnt = 0;
  endtask
  initial begin
    bus.start_in = 1'b0;
    bus.b_in = '0;
    bus.x1_in = '0;
    bus.x2_in = '0;
    bus.x3_in = '0;
    bus.x4_in = '0;
    bus.x5_in = '0;
    bus.x6_in = '0;
    xz = '{default: 32'h0};
    xs = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0};
    #2;
    do_reset("reset");
    step("one", 1'b1, 16'sd20, xz);
    chk("one const", bus.x_out, 32'h0001_0000);
    step("floor", 1'b1, -16'sd1, xz);
    chk("floor const", bus.x_out, 32'hFFFF_F333);
    step("sat", 1'b1, 16'sd32767, xs);
    chk("sat const", bus.x_out, 32'h7FFF_FFFF);
    for (int c = 0; c < 3; c++) rstep("hold", 1'b0);
    rstep("resume", 1'b1);
    // Step c observes the cycle after edge c: valid on steps 17..32, done from step 33.
    do_reset("full");
    first_v = 0;
    first_d = 0;
    for (int c = 1; c <= 36; c++) begin
      rstep("full", c <= 32 || c > 34);
      if (bus.out_valid && first_v == 0) first_v = c;
      if (bus.done_out && first_d == 0) first_d = c;
    end
    chk("full first valid", 32'(first_v), 32'd17);
    chk("full valid count", 32'(vcnt), 32'd16);
    chk("full first done", 32'(first_d), 32'd33);
    do_reset("pause");
    for (int c = 0; c < 21; c++) rstep("pause", 1'b1);
    for (int c = 0; c < 3; c++) rstep("paused", 1'b0);
    for (int c = 0; c < 11; c++) rstep("pause", 1'b1);
    for (int c = 0; c < 2; c++) rstep("pause tail", 1'b0);
    chk("pause valid count", 32'(vcnt), 32'd16);
    do_reset("abort");
    for (int c = 0; c < 20; c++) rstep("abort", 1'b1);
    #2;
    rst_n_in = 1'b0;
    #1;
    reset_model();
    check_all("abort async");
    do_reset("rerun");
    for (int c = 0; c < 34; c++) rstep("rerun", 1'b1);
    chk("rerun valid count", 32'(vcnt), 32'd16);
    chk("rerun done", 32'(bus.done_out), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
